mcycle_ctrl: RTL and testbench
==============================

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port OP, input, 6 bits: instruction opcode, inst[31:26] from the instruction register.
REQ-004 The block SHALL have port Fun, input, 6 bits: R-type function field, inst[5:0].
REQ-005 The block SHALL have port zero, input, 1 bit: datapath ALU zero flag.
REQ-006 The block SHALL have port MIO_ready, input, 1 bit: the memory/IO access completes this cycle.
REQ-007 The block SHALL have port PC_en, output, 1 bit: PC load enable, equal to PCWrite | (PCWriteCond & zero).
REQ-008 The block SHALL have ports PCWrite and PCWriteCond, outputs, 1 bit each: unconditional and branch-conditional PC write.
REQ-009 The block SHALL have ports IorD, MemRead, MemWrite, IRWrite and CPU_MIO, outputs, 1 bit each: address select (1 = ALUOut), read strobe, write strobe, instruction-register load, and memory request.
REQ-010 The block SHALL have ports RegDst, MemtoReg and RegWrite, outputs, 1 bit each: destination select (1 = rd), write-back source (1 = MDR), register write enable.
REQ-011 The block SHALL have ports ALUSrcA (1 bit), ALUSrcB (2 bits), PCSource (2 bits) and ALU_Control (3 bits), all outputs.
REQ-012 The block SHALL have port state_out, output, 5 bits: the current state encoding, for debug.

Function
REQ-013 The FSM SHALL be Moore, with these states and encodings: IF=0, ID=1, MEM_ADDR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BEQ_EX=8, J_EX=9, I_EX=10, I_WB=11.
REQ-014 Every output not named for a state SHALL be 0 in that state.
REQ-015 ALU_Control codes SHALL be: and=000, or=001, add=010, xor=011, nor=100, srl=101, sub=110, slt=111.
REQ-016 In IF the block SHALL drive MemRead=1, CPU_MIO=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU add, PCSource=00, and IRWrite=PCWrite=MIO_ready.
REQ-017 The FSM SHALL stay in IF while MIO_ready=0 and move to ID on MIO_ready=1.
REQ-018 In ID the block SHALL drive ALUSrcA=0, ALUSrcB=11, ALU add (precomputes the branch target).
REQ-019 From ID the next state SHALL be selected by OP: 100011/101011 -> MEM_ADDR; 000000 -> R_EX; 000100 -> BEQ_EX; 000010 -> J_EX; 001000/001010 -> I_EX; any other OP -> IF.
REQ-020 In MEM_ADDR the block SHALL drive ALUSrcA=1, ALUSrcB=10, ALU add; next state SHALL be MEM_RD if OP=100011, otherwise MEM_WR.
REQ-021 In MEM_RD the block SHALL drive IorD=1, MemRead=1, CPU_MIO=1; it SHALL hold until MIO_ready=1, then go to LW_WB.
REQ-022 In LW_WB the block SHALL drive RegDst=0, MemtoReg=1, RegWrite=1; next state SHALL be IF.
REQ-023 In MEM_WR the block SHALL drive IorD=1, MemWrite=1, CPU_MIO=1; it SHALL hold until MIO_ready=1, then go to IF.
REQ-024 Fun SHALL map to ALU codes as: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000010 srl.
REQ-025 In R_EX with a supported Fun, the block SHALL drive ALUSrcA=1, ALUSrcB=00, ALU per Fun, and go to R_WB.
REQ-026 In R_EX with an unsupported Fun, the next state SHALL be IF and no write SHALL occur.
REQ-027 In R_WB the block SHALL keep the R_EX ALU signals and drive RegDst=1, MemtoReg=0, RegWrite=1; next state SHALL be IF.
REQ-028 In BEQ_EX the block SHALL drive ALUSrcA=1, ALUSrcB=00, ALU sub, PCWriteCond=1, PCSource=01; next state SHALL be IF.
REQ-029 In J_EX the block SHALL drive PCWrite=1, PCSource=10; next state SHALL be IF.
REQ-030 In I_EX the block SHALL drive ALUSrcA=1, ALUSrcB=10, with ALU add for OP=001000 and slt for OP=001010; next state SHALL be I_WB.
REQ-031 In I_WB the block SHALL hold the I_EX ALU signals and drive RegDst=0, MemtoReg=0, RegWrite=1; next state SHALL be IF.
REQ-032 Instruction latency SHALL be: R/addi/slti 4 cycles; lw 5 cycles; sw, beq and j 4, 3 and 3 cycles respectively; each memory state adds its wait cycles.
REQ-033 An unknown state encoding SHALL return the FSM to IF on the next edge.

Reset
REQ-034 While rst=0 the state SHALL be IF and state_out=0, and PCWrite, PC_en, IRWrite, MemWrite, RegWrite and PCWriteCond SHALL be forced to 0, regardless of MIO_ready.
REQ-035 Reset asserted mid-instruction (including a memory wait) SHALL abort that instruction immediately, with no further writes.
REQ-036 After rst rises, the first edge with MIO_ready=1 SHALL perform the first fetch.

Verification
REQ-037 add: MIO_ready=1, OP=0, Fun=100000 -> states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7; ALU_Control=010.
REQ-038 lw with a 2-cycle MEM_RD wait -> state 3 held 2 extra cycles with IorD=1 and MemRead=1; RegWrite=1 with MemtoReg=1 in state 4; total 7 cycles.
REQ-039 beq: zero=1 -> PC_en=1 in state 8; zero=0 -> PC_en=0 and PCSource=01.
REQ-040 j -> state 9 with PCWrite=1 and PCSource=10; illegal OP=111111 -> ID then IF, with no write strobes.
REQ-041 sw with rst pulled low during MEM_WR while MIO_ready=0 -> MemWrite drops to 0 asynchronously and state_out=0.
REQ-042 IF with MIO_ready=0 for 3 cycles -> IRWrite=PCWrite=0 and the state stays 0; they pulse to 1 for one cycle when MIO_ready=1.

Source files
------------

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: Moore FSM that sequences fetch, decode,
// execute, memory and write-back phases and drives the datapath control lines.
module mcycle_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OP,
   input  logic [5:0] Fun,
   input  logic       zero,
   input  logic       MIO_ready,
   output logic       PC_en,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       CPU_MIO,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALU_Control,
   output logic [4:0] state_out
);

   typedef enum logic [4:0] {
      S_IF       = 5'd0,
      S_ID       = 5'd1,
      S_MEM_ADDR = 5'd2,
      S_MEM_RD   = 5'd3,
      S_LW_WB    = 5'd4,
      S_MEM_WR   = 5'd5,
      S_R_EX     = 5'd6,
      S_R_WB     = 5'd7,
      S_BEQ_EX   = 5'd8,
      S_J_EX     = 5'd9,
      S_I_EX     = 5'd10,
      S_I_WB     = 5'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state, state_nxt;
   logic [2:0] fun_alu;
   logic       fun_ok;
   logic       pc_write_raw, pc_write_cond_raw, mem_write_raw, ir_write_raw, reg_write_raw;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IF;
      else      state <= state_nxt;
   end

   // R-type function decode; fun_ok=0 marks an unsupported function.
   always_comb begin
      fun_ok  = 1'b1;
      fun_alu = ALU_AND;
      case (Fun)
         6'b100000: fun_alu = ALU_ADD;
         6'b100010: fun_alu = ALU_SUB;
         6'b100100: fun_alu = ALU_AND;
         6'b100101: fun_alu = ALU_OR;
         6'b100110: fun_alu = ALU_XOR;
         6'b100111: fun_alu = ALU_NOR;
         6'b101010: fun_alu = ALU_SLT;
         6'b000010: fun_alu = ALU_SRL;
         default:   fun_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt         = S_IF;
      pc_write_raw      = 1'b0;
      pc_write_cond_raw = 1'b0;
      mem_write_raw     = 1'b0;
      ir_write_raw      = 1'b0;
      reg_write_raw     = 1'b0;
      IorD              = 1'b0;
      MemRead           = 1'b0;
      CPU_MIO           = 1'b0;
      RegDst            = 1'b0;
      MemtoReg          = 1'b0;
      ALUSrcA           = 1'b0;
      ALUSrcB           = 2'b00;
      PCSource          = 2'b00;
      ALU_Control       = ALU_AND;
      case (state)
         S_IF: begin
            MemRead      = 1'b1;
            CPU_MIO      = 1'b1;
            ALUSrcB      = 2'b01;
            ALU_Control  = ALU_ADD;
            ir_write_raw = MIO_ready;
            pc_write_raw = MIO_ready;
            state_nxt    = MIO_ready ? S_ID : S_IF;
         end
         S_ID: begin
            ALUSrcB     = 2'b11;
            ALU_Control = ALU_ADD;
            case (OP)
               OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
               OP_RTYPE:         state_nxt = S_R_EX;
               OP_BEQ:           state_nxt = S_BEQ_EX;
               OP_J:             state_nxt = S_J_EX;
               OP_ADDI, OP_SLTI: state_nxt = S_I_EX;
               default:          state_nxt = S_IF;
            endcase
         end
         S_MEM_ADDR: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            ALU_Control = ALU_ADD;
            state_nxt   = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            IorD      = 1'b1;
            MemRead   = 1'b1;
            CPU_MIO   = 1'b1;
            state_nxt = MIO_ready ? S_LW_WB : S_MEM_RD;
         end
         S_LW_WB: begin
            MemtoReg      = 1'b1;
            reg_write_raw = 1'b1;
         end
         S_MEM_WR: begin
            IorD          = 1'b1;
            mem_write_raw = 1'b1;
            CPU_MIO       = 1'b1;
            state_nxt     = MIO_ready ? S_IF : S_MEM_WR;
         end
         S_R_EX: begin
            ALUSrcA     = 1'b1;
            ALU_Control = fun_ok ? fun_alu : ALU_AND;
            state_nxt   = fun_ok ? S_R_WB : S_IF;
         end
         S_R_WB: begin
            ALUSrcA       = 1'b1;
            ALU_Control   = fun_alu;
            RegDst        = 1'b1;
            reg_write_raw = 1'b1;
         end
         S_BEQ_EX: begin
            ALUSrcA           = 1'b1;
            ALU_Control       = ALU_SUB;
            pc_write_cond_raw = 1'b1;
            PCSource          = 2'b01;
         end
         S_J_EX: begin
            pc_write_raw = 1'b1;
            PCSource     = 2'b10;
         end
         S_I_EX: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            ALU_Control = (OP == OP_SLTI) ? ALU_SLT : ALU_ADD;
            state_nxt   = S_I_WB;
         end
         S_I_WB: begin
            ALUSrcA       = 1'b1;
            ALUSrcB       = 2'b10;
            ALU_Control   = (OP == OP_SLTI) ? ALU_SLT : ALU_ADD;
            reg_write_raw = 1'b1;
         end
         default: state_nxt = S_IF;
      endcase
   end

   // Write strobes are gated by reset so they drop the instant rst falls.
   assign PCWrite     = pc_write_raw & rst;
   assign PCWriteCond = pc_write_cond_raw & rst;
   assign MemWrite    = mem_write_raw & rst;
   assign IRWrite     = ir_write_raw & rst;
   assign RegWrite    = reg_write_raw & rst;
   assign PC_en       = PCWrite | (PCWriteCond & zero);
   assign state_out   = state;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Randomized bench for mcycle_ctrl: per-instruction state plans plus a state-table
// output model, checked every cycle on the falling clock edge.
module tb_mcycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] OP, Fun;
   logic       zero, MIO_ready;
   logic       PC_en, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, CPU_MIO;
   logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALU_Control;
   logic [4:0] state_out;

   typedef struct packed {
      logic       pc_en, pcw, pcwc, iord, mrd, mwr, irw, mio, rdst, m2r, rw, srca;
      logic [1:0] srcb, pcs;
      logic [2:0] alu;
   } outs_t;

   int n_cmp = 0;
   int n_err = 0;
   int exp_state;
   bit exp_valid = 1'b0;
   int trace_q[$];
   int plan_st[$];
   bit plan_mio[$];

   mcycle_ctrl dut (
      .clk(clk), .rst(rst), .OP(OP), .Fun(Fun), .zero(zero), .MIO_ready(MIO_ready),
      .PC_en(PC_en), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .CPU_MIO(CPU_MIO),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_Control(ALU_Control),
      .state_out(state_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic bit fun_lookup(input logic [5:0] f, output logic [2:0] code);
      code = 3'b000;
      case (f)
         6'h20: code = 3'b010;
         6'h22: code = 3'b110;
         6'h24: code = 3'b000;
         6'h25: code = 3'b001;
         6'h26: code = 3'b011;
         6'h27: code = 3'b100;
         6'h2a: code = 3'b111;
         6'h02: code = 3'b101;
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   // Output table indexed by state name, straight from the control-line list per phase.
   function automatic outs_t model_outs(input int st, input logic [5:0] op, input logic [5:0] fun,
                                        input logic z, input logic mio, input logic rstn);
      outs_t o;
      logic [2:0] fc;
      bit ok;
      o = '0;
      ok = fun_lookup(fun, fc);
      case (st)
         0:  begin o.mrd = 1; o.mio = 1; o.srcb = 2'b01; o.alu = 3'b010; o.irw = mio; o.pcw = mio; end
         1:  begin o.srcb = 2'b11; o.alu = 3'b010; end
         2:  begin o.srca = 1; o.srcb = 2'b10; o.alu = 3'b010; end
         3:  begin o.iord = 1; o.mrd = 1; o.mio = 1; end
         4:  begin o.m2r = 1; o.rw = 1; end
         5:  begin o.iord = 1; o.mwr = 1; o.mio = 1; end
         6:  begin o.srca = 1; o.alu = ok ? fc : 3'b000; end
         7:  begin o.srca = 1; o.alu = fc; o.rdst = 1; o.rw = 1; end
         8:  begin o.srca = 1; o.alu = 3'b110; o.pcwc = 1; o.pcs = 2'b01; end
         9:  begin o.pcw = 1; o.pcs = 2'b10; end
         10: begin o.srca = 1; o.srcb = 2'b10; o.alu = (op == 6'h0a) ? 3'b111 : 3'b010; end
         11: begin o.srca = 1; o.srcb = 2'b10; o.alu = (op == 6'h0a) ? 3'b111 : 3'b010; o.rw = 1; end
         default: ;
      endcase
      if (!rstn) begin o.pcw = 0; o.pcwc = 0; o.irw = 0; o.mwr = 0; o.rw = 0; end
      o.pc_en = o.pcw | (o.pcwc & z);
      return o;
   endfunction

   function automatic outs_t dut_outs();
      outs_t a;
      a = {PC_en, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, CPU_MIO,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALU_Control};
      return a;
   endfunction

   // Compare process: every meaningful cycle, state and all outputs against the model.
   always @(negedge clk) begin
      if (exp_valid) begin
         outs_t e, a;
         chk("state", int'(state_out), exp_state);
         e = model_outs(exp_state, OP, Fun, zero, MIO_ready, rst);
         a = dut_outs();
         n_cmp++;
         if (a !== e) begin
            n_err++;
            $display("FAIL outs st=%0d op=%h fun=%h actual=%h required=%h",
                     exp_state, OP, Fun, a, e);
         end
         trace_q.push_back(int'(state_out));
      end
   end

   // Build the cycle-by-cycle state plan for one instruction, then drive it.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fun,
                            input int w_if, input int w_mem);
      logic [2:0] fc;
      plan_st.delete();
      plan_mio.delete();
      for (int i = 0; i < w_if; i++) begin plan_st.push_back(0); plan_mio.push_back(1'b0); end
      plan_st.push_back(0); plan_mio.push_back(1'b1);
      plan_st.push_back(1); plan_mio.push_back(1'($urandom_range(0, 1)));
      case (op)
         6'h23: begin
            plan_st.push_back(2); plan_mio.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < w_mem; i++) begin plan_st.push_back(3); plan_mio.push_back(1'b0); end
            plan_st.push_back(3); plan_mio.push_back(1'b1);
            plan_st.push_back(4); plan_mio.push_back(1'($urandom_range(0, 1)));
         end
         6'h2b: begin
            plan_st.push_back(2); plan_mio.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < w_mem; i++) begin plan_st.push_back(5); plan_mio.push_back(1'b0); end
            plan_st.push_back(5); plan_mio.push_back(1'b1);
         end
         6'h00: begin
            plan_st.push_back(6); plan_mio.push_back(1'($urandom_range(0, 1)));
            if (fun_lookup(fun, fc)) begin plan_st.push_back(7); plan_mio.push_back(1'($urandom_range(0, 1))); end
         end
         6'h04: begin plan_st.push_back(8); plan_mio.push_back(1'($urandom_range(0, 1))); end
         6'h02: begin plan_st.push_back(9); plan_mio.push_back(1'($urandom_range(0, 1))); end
         6'h08, 6'h0a: begin
            plan_st.push_back(10); plan_mio.push_back(1'($urandom_range(0, 1)));
            plan_st.push_back(11); plan_mio.push_back(1'($urandom_range(0, 1)));
         end
         default: ;
      endcase
      for (int i = 0; i < plan_st.size(); i++) begin
         OP = op;
         Fun = fun;
         zero = 1'($urandom_range(0, 1));
         MIO_ready = plan_mio[i];
         exp_state = plan_st[i];
         exp_valid = 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   logic [5:0] op_tab[9]  = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h04, 6'h02, 6'h08, 6'h0a, 6'h3f};
   logic [5:0] fun_tab[9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02, 6'h3f};

   initial begin
      rst = 1'b0; OP = 6'h00; Fun = 6'h20; zero = 1'b0; MIO_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_state", int'(state_out), 0);
      chk("rst_irwrite", int'(IRWrite), 0);
      chk("rst_pcwrite", int'(PCWrite), 0);
      chk("rst_pc_en", int'(PC_en), 0);
      @(posedge clk); #1;
      rst = 1'b1;

      trace_q.delete();
      run_instr(6'h00, 6'h20, 0, 0);
      chk("add_len", trace_q.size(), 4);
      chk("add_s1", trace_q[1], 1);
      chk("add_s2", trace_q[2], 6);
      chk("add_s3", trace_q[3], 7);

      trace_q.delete();
      run_instr(6'h23, 6'h00, 0, 2);
      chk("lw_len", trace_q.size(), 7);
      chk("lw_wait", trace_q[5], 3);
      chk("lw_wb", trace_q[6], 4);

      trace_q.delete();
      run_instr(6'h02, 6'h00, 0, 0);
      chk("j_s2", trace_q[2], 9);
      trace_q.delete();
      run_instr(6'h3f, 6'h00, 3, 0);
      chk("ill_len", trace_q.size(), 5);
      run_instr(6'h04, 6'h00, 0, 0);
      run_instr(6'h00, 6'h3f, 0, 0);
      run_instr(6'h00, 6'h20, 0, 0);
      chk("after_ill_fetch", int'(state_out), 0);

      // sw aborted by reset during a memory wait
      plan_st.delete();
      OP = 6'h2b; Fun = 6'h00;
      foreach (op_tab[i]) if (i < 3) begin
         MIO_ready = (i == 0);
         exp_state = i;
         exp_valid = 1'b1;
         @(posedge clk); #1;
      end
      exp_state = 5; MIO_ready = 1'b0;
      @(posedge clk); #1;
      exp_valid = 1'b0;
      chk("sw_wait_state", int'(state_out), 5);
      chk("sw_memwrite", int'(MemWrite), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_memwrite", int'(MemWrite), 0);
      chk("abort_state", int'(state_out), 0);
      MIO_ready = 1'b1;
      @(negedge clk);
      chk("abort_irwrite", int'(IRWrite), 0);
      chk("abort_pcwrite", int'(PCWrite), 0);
      chk("abort_state_held", int'(state_out), 0);
      @(posedge clk); #1;
      rst = 1'b1;

      run_instr(6'h00, 6'h22, 3, 0);
      for (int n = 0; n < 80; n++) begin
         logic [5:0] op, fun;
         op  = op_tab[$urandom_range(0, 8)];
         fun = fun_tab[$urandom_range(0, 8)];
         if ($urandom_range(0, 9) == 0) op = 6'($urandom);
         run_instr(op, fun, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      exp_valid = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
